fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of the instruction decoder. Holds the program counter, issues word requests to a synchronous instruction memory with fixed 1-cycle read latency, and buffers returned words in a 2-entry FIFO. Presents `{instruction, pc}` pairs to the decoder over a valid/ready handshake. Accepts redirects (branch/jump targets) from execute, which flush all wrong-path state.

---
 rtl/fetch_unit_if.sv | 47 ++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundle of the fetch-stage bus signals: the redirect input
//                from execute, the instruction-memory request/response, and
//                the valid/ready instruction stream toward the decoder.
//  Ports       : none (clock and reset stay plain ports on the modules)
//  Modports    : master - the fetch unit (drives imem_req/addr, out_*)
//                slave  - the environment (execute, imem, decoder)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        input  imem_rdata,
        input  out_ready,
        output imem_req,
        output imem_addr,
        output out_valid,
        output out_instruction,
        output out_pc
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        output imem_rdata,
        output out_ready,
        input  imem_req,
        input  imem_addr,
        input  out_valid,
        input  out_instruction,
        input  out_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I instruction fetch stage. Holds the PC, issues word
//                reads to a 1-cycle-latency synchronous instruction memory,
//                buffers returned words in a 2-entry FIFO and hands
//                {instruction, pc} pairs to the decoder over valid/ready.
//                A redirect flushes the FIFO and the outstanding request.
//  Ports       : clk  - clock, all state updates on the rising edge
//                rst  - synchronous active-high reset
//                bus  - fetch_unit_if.master (redirect, imem, decoder stream)
//  Parameters  : RESET_PC - first fetch address after reset (word aligned)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fetch_unit_if.master bus
);

    localparam logic [31:0] c_reset_pc   = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;
    localparam logic [31:0] c_pc_step    = 32'd4;

    // Fetch state
    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;

    // 2-entry FIFO of {instr, pc}; 1-bit pointers wrap naturally
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_pc    [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_occ;

    logic        w_valid;
    logic        w_pop;
    logic        w_req;
    logic [2:0]  w_committed;
    logic [31:0] w_redirect_target;

    always_comb begin
        w_redirect_target = bus.redirect_pc & c_align_mask;
        w_valid           = !rst && !bus.redirect_valid && (r_occ != 2'd0);
        w_pop             = w_valid && bus.out_ready;
        // Slots already claimed once this cycle's pop is accounted for:
        // buffered words plus the word still coming back from memory.
        // Counting the pop lets the request reassert in the very cycle the
        // decoder drains a full FIFO, keeping throughput at one per cycle.
        w_committed       = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_req             = !rst && !bus.redirect_valid && (w_committed < 3'd2);
    end

    assign bus.imem_req        = w_req;
    assign bus.imem_addr       = r_pc;
    assign bus.out_valid       = w_valid;
    assign bus.out_instruction = r_fifo_instr[r_rd_ptr];
    assign bus.out_pc          = r_fifo_pc[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= c_reset_pc;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Clearing r_inflight drops the response that lands next cycle
            r_pc       <= w_redirect_target;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else begin
            if (r_inflight) begin
                r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
                r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
                r_wr_ptr               <= ~r_wr_ptr;
            end

            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase

            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + c_pc_step;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A synchronous memory
//                returns mem[a] = a ^ 32'hA5A5_0000. A queue-based model of
//                the fetch pipeline is compared with the DUT every cycle,
//                directed scenarios pin literal values, and a randomized
//                phase mixes backpressure, redirects and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] MEM_XOR  = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous instruction memory, 1-cycle latency; garbage when idle
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= bus.imem_addr ^ MEM_XOR;
        else              bus.imem_rdata <= $urandom;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of buffered PCs, one outstanding request,
    // and the next PC the decoder must see (consecutive since last flush).
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic        m_inflight;
    logic [31:0] m_inflight_pc;
    logic [31:0] m_q [$];
    logic [31:0] m_next_deliver;
    logic        m_known = 1'b0;

    always @(negedge clk) begin
        logic e_valid;
        logic e_pop;
        logic e_req;
        int   claimed;
        if (rst) begin
            chk("rst_imem_req", bus.imem_req, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            m_pc           = RESET_PC;
            m_inflight     = 1'b0;
            m_q.delete();
            m_next_deliver = RESET_PC;
            m_known        = 1'b1;
        end else if (m_known) begin
            if (bus.redirect_valid) begin
                chk("redir_imem_req", bus.imem_req, 0);
                chk("redir_out_valid", bus.out_valid, 0);
                m_pc           = bus.redirect_pc & 32'hFFFF_FFFC;
                m_inflight     = 1'b0;
                m_q.delete();
                m_next_deliver = m_pc;
            end else begin
                e_valid = (m_q.size() != 0);
                e_pop   = e_valid && bus.out_ready;
                claimed = m_q.size() + int'(m_inflight) - int'(e_pop);
                e_req   = (claimed < 2);
                chk("model_out_valid", bus.out_valid, e_valid);
                chk("model_imem_req", bus.imem_req, e_req);
                if (e_req) chk("model_imem_addr", bus.imem_addr, m_pc);
                if (e_valid) begin
                    chk("model_out_pc", bus.out_pc, m_q[0]);
                    chk("model_out_instr", bus.out_instruction, m_q[0] ^ MEM_XOR);
                end
                if (e_pop) begin
                    chk("stream_order", bus.out_pc, m_next_deliver);
                    m_next_deliver = m_next_deliver + 32'd4;
                    void'(m_q.pop_front());
                end
                if (m_inflight) m_q.push_back(m_inflight_pc);
                m_inflight = e_req;
                if (e_req) begin
                    m_inflight_pc = m_pc;
                    m_pc          = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] wrap_exp [3];

    initial begin
        int got;
        rst                 = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.out_ready       = 1'b1;
        wrap_exp[0]         = 32'hFFFF_FFF8;
        wrap_exp[1]         = 32'hFFFF_FFFC;
        wrap_exp[2]         = 32'h0000_0000;
        repeat (3) next_cycle();

        // ---- Reset fetch ----
        rst = 1'b0;                                   // cycle 0
        @(negedge clk);
        chk("c0_imem_req", bus.imem_req, 1);
        chk("c0_imem_addr", bus.imem_addr, 32'h100);
        @(negedge clk);                               // cycle 1
        chk("c1_out_valid", bus.out_valid, 0);
        chk("c1_imem_addr", bus.imem_addr, 32'h104);
        @(negedge clk);                               // cycle 2
        chk("c2_out_valid", bus.out_valid, 1);
        chk("c2_out_pc", bus.out_pc, 32'h100);
        chk("c2_out_instr", bus.out_instruction, 32'hA5A5_0100);

        // ---- Backpressure: ready low for cycles 3..7 ----
        next_cycle();
        bus.out_ready = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);                               // cycle 7
        chk("bp_imem_req", bus.imem_req, 0);
        chk("bp_out_pc", bus.out_pc, 32'h104);
        next_cycle();
        bus.out_ready = 1'b1;                         // cycle 8
        @(negedge clk);
        chk("rel_imem_req", bus.imem_req, 1);
        chk("rel_out_pc0", bus.out_pc, 32'h104);
        @(negedge clk);
        chk("rel_valid1", bus.out_valid, 1);
        chk("rel_out_pc1", bus.out_pc, 32'h108);
        @(negedge clk);
        chk("rel_valid2", bus.out_valid, 1);
        chk("rel_out_pc2", bus.out_pc, 32'h10C);

        // ---- Redirect with a full FIFO ----
        next_cycle();
        bus.out_ready = 1'b0;
        repeat (3) next_cycle();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2003;           // cycle R
        @(negedge clk);
        chk("R_out_valid", bus.out_valid, 0);
        next_cycle();
        bus.redirect_valid = 1'b0;                    // R+1
        @(negedge clk);
        chk("R1_imem_req", bus.imem_req, 1);
        chk("R1_imem_addr", bus.imem_addr, 32'h2000);
        @(negedge clk);                               // R+2
        chk("R2_out_valid", bus.out_valid, 0);
        @(negedge clk);                               // R+3
        chk("R3_out_valid", bus.out_valid, 1);
        chk("R3_out_pc", bus.out_pc, 32'h2000);

        // ---- Simultaneous redirect, ready and pending capture ----
        next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_3000;
        @(negedge clk);
        chk("sim_out_valid", bus.out_valid, 0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("sim_empty_next", bus.out_valid, 0);
        chk("sim_imem_addr", bus.imem_addr, 32'h3000);

        // ---- Wrap-around ----
        next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        next_cycle();
        bus.redirect_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk("wrap_out_pc", bus.out_pc, wrap_exp[got]);
                got++;
            end
        end
        if (got < 3) chk("wrap_timeout", got, 3);

        // ---- Reset mid-stream with words buffered ----
        next_cycle();
        bus.out_ready = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst           = 1'b0;
        bus.out_ready = 1'b1;                         // cycle 0 again
        @(negedge clk);
        chk("rr_c0_imem_req", bus.imem_req, 1);
        chk("rr_c0_imem_addr", bus.imem_addr, 32'h100);
        @(negedge clk);
        chk("rr_c1_out_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("rr_c2_out_valid", bus.out_valid, 1);
        chk("rr_c2_out_pc", bus.out_pc, 32'h100);

        // ---- Randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 24) == 0);
            bus.redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                             : $urandom;
            rst                = ($urandom_range(0, 299) == 0);
        end
        next_cycle();
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        repeat (4) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
